// File: rtl/dpe_pkg.sv
// Shared DPE types: AXIS datapath widths and TX arbiter state encoding.
// Imported by the TX arbiter and its round-robin picker.
package dpe_pkg;

  localparam int DPE_AXIS_DW = 128;
  localparam int DPE_AXIS_KW = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_PKT
  } arb_state_t;

endpackage

// File: rtl/dpe_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr (circular).
// Ports: req_i request vector, ptr_i start index, gnt_o one-hot, idx_o index, any_o.
module dpe_rr_pick
  import dpe_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin : pick
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dpe_tx_pkt_arbiter.sv
// Frame-granular round-robin arbiter of NUM_SRC AXIS sources onto one
// registered AXIS TX port. Ports: s_* sources (slice i = source i), m_* to
// MAC, grant/busy status, frame_cnt per-source forwarded-frame counters.
module dpe_tx_pkt_arbiter
  import dpe_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = DPE_AXIS_DW,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0]  s_tkeep,
  input  logic [NUM_SRC*USER_WIDTH-1:0]    s_tuser,
  input  logic [NUM_SRC-1:0]               s_tlast,
  input  logic [NUM_SRC-1:0]               s_tvalid,
  output logic [NUM_SRC-1:0]               s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [DATA_WIDTH/8-1:0]          m_tkeep,
  output logic [USER_WIDTH-1:0]            m_tuser,
  output logic                             m_tlast,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [NUM_SRC-1:0]               grant,
  output logic                             busy,
  output logic [NUM_SRC*CNT_WIDTH-1:0]     frame_cnt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  arb_state_t state_q, state_d;

  logic [NUM_SRC-1:0]    grant_q;
  logic [IW-1:0]         gidx_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [IW-1:0]         ptr_nxt;

  logic [NUM_SRC-1:0]    pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KW-1:0]         sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_last;
  logic                  sel_valid;

  logic                  out_rdy;
  logic                  accept;
  logic                  eof;

  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic [KW-1:0]         m_tkeep_q;
  logic [USER_WIDTH-1:0] m_tuser_q;
  logic                  m_tlast_q;
  logic                  m_tvalid_q;

  dpe_rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req_i (s_tvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign sel_data  = s_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_tkeep[gidx_q*KW +: KW];
  assign sel_user  = s_tuser[gidx_q*USER_WIDTH +: USER_WIDTH];
  assign sel_last  = s_tlast[gidx_q];
  assign sel_valid = s_tvalid[gidx_q];

  // Output register can take a beat when empty or draining this cycle.
  assign out_rdy = !m_tvalid_q || m_tready;
  assign accept  = (state_q == ARB_PKT) && sel_valid && out_rdy;
  assign eof     = accept && sel_last;

  assign ptr_nxt = (gidx_q == IW'(NUM_SRC - 1)) ? '0 : gidx_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (pick_any) state_d = ARB_PKT;
      ARB_PKT:  if (eof)      state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ARB_PKT);
    s_tready = (busy && out_rdy) ? grant_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else if (state_q == ARB_IDLE && pick_any) begin
      grant_q <= pick_gnt;
      gidx_q  <= pick_idx;
    end else if (eof) begin
      grant_q  <= '0;
      rr_ptr_q <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
    end else if (accept) begin
      m_tvalid_q <= 1'b1;
      m_tlast_q  <= sel_last;
      m_tdata_q  <= sel_data;
      m_tkeep_q  <= sel_keep;
      m_tuser_q  <= sel_user;
    end else if (m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (eof && gidx_q == IW'(i)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
    assign frame_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  assign grant    = grant_q;
  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tuser  = m_tuser_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_dpe_tx_pkt_arbiter.sv
// Scoreboard bench for dpe_tx_pkt_arbiter: per-source expected frame queues,
// directed round-robin/backpressure/gap/reset cases plus random traffic.
module tb_dpe_tx_pkt_arbiter;

  localparam int NS = 4;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 1;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            gap;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KW-1:0]  s_tkeep;
  logic [NS*UW-1:0]  s_tuser;
  logic [NS-1:0]     s_tlast;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [NS-1:0]     grant;
  logic              busy;
  logic [NS*CW-1:0]  frame_cnt;

  dpe_tx_pkt_arbiter #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tuser   (s_tuser),
    .s_tlast   (s_tlast),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .grant     (grant),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  beat_t         drv_q [NS][$];
  beat_t         exp_q [NS][$];
  int            order_q [$];
  int            gapcnt [NS];
  int            sent [NS];
  int            exp_frames [NS];
  logic [NS-1:0] hs = '0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            tready_mode = 0;
  int            tr_idx = 0;
  int            cyc = 0;
  int            fseq = 0;

  bit            mon_in_frame = 0;
  int            mon_src = 0;
  bit            have_last = 0;
  int            last_cyc = 0;
  bit            idle_chk = 0;
  bit            thr_chk = 0;
  int            fr_start = 0;
  int            fr_beats = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] h_data;
  logic [KW-1:0] h_keep;
  logic          h_last;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Beat sampled as transferred on this rising edge.
  always @(posedge clk) hs <= s_tvalid & s_tready;

  // Source drivers and m_tready generator; inputs change on the falling edge.
  always @(negedge clk) begin : drv
    beat_t b;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (!rst_n) begin
        s_tvalid[i] = 1'b0;
      end else begin
        if (hs[i] && drv_q[i].size() > 0) begin
          drv_q[i].delete(0);
          sent[i]++;
          gapcnt[i] = 0;
          s_tvalid[i] = 1'b0;
        end
        if (!s_tvalid[i] && drv_q[i].size() > 0) begin
          b = drv_q[i][0];
          if (gapcnt[i] < b.gap) begin
            gapcnt[i]++;
          end else begin
            s_tdata[i*DW +: DW] = b.data;
            s_tkeep[i*KW +: KW] = b.keep;
            s_tuser[i*UW +: UW] = b.user;
            s_tlast[i]          = b.last;
            s_tvalid[i]         = 1'b1;
          end
        end
      end
    end
    case (tready_mode)
      1: begin
        m_tready = (tr_idx == 1 || tr_idx == 2) ? 1'b0 : 1'b1;
        tr_idx   = (tr_idx + 1) % 4;
      end
      2: m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b1;
    endcase
  end

  // Monitor: pops the per-source scoreboard on every output transfer.
  initial begin : mon
    beat_t       e;
    logic [7:0]  sid;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        chk("grant_onehot0", {127'd0, $onehot0(grant)}, 128'd1);
        chk("busy_grant", {127'd0, busy}, {127'd0, |grant});
        chk("s_tready_in_grant", s_tready & ~grant, 0);
        if (m_tvalid && !m_tready)
          chk("s_tready_stall", s_tready, 0);
        if (prev_stall) begin
          chk("stall_valid", {127'd0, m_tvalid}, 128'd1);
          chk("stall_data", m_tdata, h_data);
          chk("stall_keep", m_tkeep, h_keep);
          chk("stall_last", {127'd0, m_tlast}, {127'd0, h_last});
        end
        if (m_tvalid && m_tready) begin
          sid = m_tdata[DW-1 -: 8];
          if (!mon_in_frame) begin
            if (sid >= NS) begin
              fail_now("frame_src_id", int'(sid), NS - 1);
            end else begin
              mon_src      = int'(sid);
              mon_in_frame = 1;
              fr_start     = cyc;
              fr_beats     = 0;
              if (order_q.size() > 0)
                chk("rr_order", sid, order_q.pop_front());
              if (idle_chk && have_last)
                chk("idle_gap", cyc - last_cyc, 2);
            end
          end
          if (mon_in_frame) begin
            fr_beats++;
            if (exp_q[mon_src].size() == 0) begin
              fail_now("unexpected_beat", mon_src, -1);
            end else begin
              e = exp_q[mon_src].pop_front();
              chk("beat_data", m_tdata, e.data);
              chk("beat_keep", m_tkeep, e.keep);
              chk("beat_user", m_tuser, e.user);
              chk("beat_last", {127'd0, m_tlast}, {127'd0, e.last});
            end
            if (m_tlast) begin
              if (thr_chk)
                chk("throughput", cyc - fr_start, fr_beats - 1);
              mon_in_frame = 0;
              last_cyc     = cyc;
              have_last    = 1;
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        h_data     = m_tdata;
        h_keep     = m_tkeep;
        h_last     = m_tlast;
      end
    end
  end

  task automatic load_frame(input int src, input int nb,
                            input logic [KW-1:0] lk, input int gap_at,
                            input int gap_len, input bit rnd);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data = {8'(src), 16'(fseq), 8'(k), $urandom(), $urandom(), $urandom()};
      b.last = (k == nb - 1);
      b.keep = b.last ? lk : '1;
      b.user = UW'($urandom_range(0, 1));
      if (k == gap_at)
        b.gap = gap_len;
      else if (rnd && $urandom_range(0, 3) == 0)
        b.gap = $urandom_range(1, 3);
      else
        b.gap = 0;
      drv_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
    exp_frames[src]++;
    fseq++;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
      gapcnt[i]     = 0;
      sent[i]       = 0;
      exp_frames[i] = 0;
    end
    order_q.delete();
    s_tvalid     = '0;
    mon_in_frame = 0;
    have_last    = 0;
    prev_stall   = 0;
    #1;
    chk("rst_m_tvalid", {127'd0, m_tvalid}, 0);
    chk("rst_m_tlast", {127'd0, m_tlast}, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", {127'd0, busy}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pending();
    int n;
    n = int'(m_tvalid);
    for (int i = 0; i < NS; i++)
      n += drv_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  task automatic wait_drain(input int maxc);
    int c;
    c = 0;
    while (pending() > 0 && c < maxc) begin
      @(negedge clk);
      #2;
      c++;
    end
    if (c >= maxc)
      fail_now("drain_timeout", pending(), 0);
    else
      n_chk++;
    chk("order_consumed", order_q.size(), 0);
  endtask

  task automatic chk_counts();
    for (int i = 0; i < NS; i++)
      chk("frame_cnt", frame_cnt[i*CW +: CW], CW'(exp_frames[i]));
  endtask

  initial begin : main
    int c;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tlast  = '0;
    s_tvalid = '0;
    m_tready = 1'b1;

    do_reset(4);

    // Single 11-beat frame from source 0, latency and throughput.
    thr_chk = 1;
    @(posedge clk);
    order_q.push_back(0);
    load_frame(0, 11, 16'h03FF, -1, 0, 0);
    c = 0;
    do begin
      @(negedge clk);
      #2;
      c++;
    end while (!(s_tvalid[0] && s_tready[0]) && c < 50);
    if (c >= 50) fail_now("first_accept_timeout", c, 50);
    chk("pre_first_valid", {127'd0, m_tvalid}, 0);
    @(negedge clk);
    #2;
    chk("latency_valid", {127'd0, m_tvalid}, 128'd1);
    wait_drain(200);
    chk_counts();

    // Round robin with all four sources pending from the same cycle.
    do_reset(2);
    idle_chk = 1;
    @(posedge clk);
    order_q = '{0, 1, 2, 3, 0};
    load_frame(0, 5, '1, -1, 0, 0);
    load_frame(1, 5, '1, -1, 0, 0);
    load_frame(2, 5, '1, -1, 0, 0);
    load_frame(3, 5, '1, -1, 0, 0);
    load_frame(0, 5, '1, -1, 0, 0);
    wait_drain(400);
    chk_counts();
    idle_chk = 0;
    thr_chk  = 0;

    // Backpressure pattern 1,0,0,1 during a frame.
    tready_mode = 1;
    @(posedge clk);
    order_q.push_back(2);
    load_frame(2, 12, 16'h00FF, -1, 0, 0);
    wait_drain(400);
    tready_mode = 0;
    chk_counts();

    // Source 1 gap of 3 cycles at beat 4 while source 2 waits.
    @(posedge clk);
    order_q.push_back(1);
    order_q.push_back(2);
    load_frame(1, 8, '1, 3, 3, 0);
    c = 0;
    while (sent[1] < 2 && c < 100) begin
      @(posedge clk);
      c++;
    end
    load_frame(2, 4, 16'h000F, -1, 0, 0);
    c = 0;
    while (exp_q[1].size() > 0 && c < 200) begin
      @(negedge clk);
      #2;
      c++;
      if (busy) chk("grant_hold", grant, 4'b0010);
    end
    wait_drain(400);
    chk_counts();

    // Reset in the middle of a source-3 frame.
    @(posedge clk);
    load_frame(3, 10, '1, -1, 0, 0);
    c = 0;
    while (sent[3] < 6 && c < 200) begin
      @(posedge clk);
      c++;
    end
    if (c >= 200) fail_now("mid_frame_timeout", sent[3], 6);
    do_reset(3);
    @(posedge clk);
    order_q.push_back(0);
    order_q.push_back(3);
    load_frame(3, 3, '1, -1, 0, 0);
    load_frame(0, 1, 16'h0001, -1, 0, 0);
    wait_drain(200);
    chk_counts();

    // Random traffic with random backpressure and source gaps.
    tready_mode = 2;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      load_frame($urandom_range(0, NS - 1), $urandom_range(1, 8),
                 KW'($urandom_range(1, 16'hFFFF)), -1, 0, 1);
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    wait_drain(8000);
    tready_mode = 0;
    chk_counts();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks",
             n_chk);
    $fatal(1, "watchdog");
  end

endmodule
